output_display: RTL

OUTPUT_DISPLAY -- requirements
Module: output_display

---
 rtl/output_display_pkg.sv | 18 +
 rtl/output_display_hex_to_seg7.sv | 11 +
 rtl/output_display.sv | 127 ++++++++++++
 3 files changed

// File: rtl/output_display_pkg.sv
// rtl/output_display_pkg.sv - shared state type, glyph table and blank code for output_display
package output_display_pkg;

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_SHOW  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit 6..0 = g..a
  localparam logic [6:0] GLYPHS [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/output_display_hex_to_seg7.sv
// rtl/output_display_hex_to_seg7.sv - hex nibble to active-low seven-segment glyph
module hex_to_seg7
  import output_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = GLYPHS[nibble];

endmodule

// File: rtl/output_display.sv
// rtl/output_display.sv - debounced CPU output port shown on a multiplexed seven-segment display
// Optional leading-zero blanking: define OUTPUT_DISPLAY_LZB_EN.
module output_display
  import output_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 50000,
  parameter int STABLE_CYCLES = 2,
  parameter int BLINK_FRAMES  = 64
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [31:0]           Output_Data,
  input  logic                  Run,
  output logic [6:0]            Seg_N,
  output logic                  Dp_N,
  output logic [NUM_DIGITS-1:0] Digit_En_N,
  output logic                  Halt_LED
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  state_t          state, state_next;
  logic [31:0]     candidate, shown;
  logic [CW-1:0]   stable_cnt;
  logic [PW-1:0]   presc;
  logic [IW-1:0]   idx;
  logic [BW-1:0]   blink_cnt;
  logic            blink_on;
  logic            capture, presc_tc, frame_done, lead_blank;
  logic [3:0]      nibble;
  logic [6:0]      glyph;

  // Input must still match the candidate so a change lasting exactly
  // STABLE_CYCLES cycles is rejected.
  assign capture    = (stable_cnt == CW'(STABLE_CYCLES - 1)) &&
                      (Output_Data == candidate) && (candidate != shown);
  assign presc_tc   = (presc == PW'(REFRESH_DIV - 1));
  assign frame_done = presc_tc && (idx == IW'(NUM_DIGITS - 1));
  assign nibble     = 4'(shown >> {idx, 2'b00});
  assign Halt_LED   = (state == S_HALT);

`ifdef OUTPUT_DISPLAY_LZB_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (4'(shown >> (4 * i)) != 4'h0) msd = IW'(i);
    end
  end

  assign lead_blank = (idx > msd);
`else
  assign lead_blank = 1'b0;
`endif

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg_n  (glyph)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_BLANK: if (capture) state_next = S_SHOW;
      S_SHOW:  if (!Run)    state_next = S_HALT;
      S_HALT:  if (Run)     state_next = S_SHOW;
      default:              state_next = S_BLANK;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_BLANK;
      candidate  <= '0;
      shown      <= '0;
      stable_cnt <= '0;
      presc      <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b0;
      Seg_N      <= SEG_BLANK;
      Dp_N       <= 1'b1;
      Digit_En_N <= '1;
    end else begin
      state <= state_next;

      if (Output_Data != candidate) begin
        candidate  <= Output_Data;
        stable_cnt <= '0;
      end else if (stable_cnt != CW'(STABLE_CYCLES - 1)) begin
        stable_cnt <= stable_cnt + CW'(1);
      end

      // Halt freezes the display while the filter keeps tracking.
      if (capture && state != S_HALT) shown <= candidate;

      if (presc_tc) begin
        presc <= '0;
        idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end

      if (state != S_HALT && state_next == S_HALT) begin
        blink_cnt <= '0;
        blink_on  <= 1'b0;
      end else if (state == S_HALT && frame_done) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      Seg_N      <= (state == S_BLANK || lead_blank) ? SEG_BLANK : glyph;
      Digit_En_N <= ~(NUM_DIGITS'(1) << idx);
      Dp_N       <= ~((state == S_HALT) && blink_on);
    end
  end

endmodule
